// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: destination tracking and RAW hazard control for the
// 5-stage pipeline. It selects the ID destination (rd or rt), follows it
// through EX, MEM and WB, and produces the stall, bubble and ALU operand
// forwarding selects.
//
// Build option: define HAZARD_FWD_EN to enable operand forwarding. Without
// it, fwd_a/fwd_b are tied to 00. Any source that matches a pending EX or
// MEM write then stalls until the producer reaches WB.
module hazard_scoreboard #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_dst,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_uses_rt,
    input  logic             flush,
    output logic             stall,
    output logic [REG_W-1:0] ex_dest,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [REG_W-1:0] wb_dest,
    output logic             wb_we,
    output logic [CNT_W-1:0] stall_cnt
);

    // EX stage record
    logic             r_ex_valid;
    logic [REG_W-1:0] r_ex_dest;
    logic [REG_W-1:0] r_ex_rs;
    logic [REG_W-1:0] r_ex_rt;
    logic             r_ex_uses_rt;
    logic             r_ex_we;
    logic             r_ex_mem_read;

    // MEM and WB stage records
    logic             r_mem_valid;
    logic [REG_W-1:0] r_mem_dest;
    logic             r_mem_we;
    logic             r_wb_valid;
    logic [REG_W-1:0] r_wb_dest;
    logic             r_wb_we;

    logic [CNT_W-1:0] r_stall_cnt;

    logic [REG_W-1:0] w_id_dest;
    logic             w_id_we;
    logic             w_accept;
    logic             w_ex_hit;

    // A destination of register 0 is stored as a non-writer, so it never matches
    assign w_id_dest = id_reg_dst ? id_rd : id_rt;
    assign w_id_we   = id_reg_write && (w_id_dest != '0);
    assign w_accept  = id_valid && !flush && !stall;

    assign w_ex_hit = r_ex_valid && r_ex_we &&
                      ((r_ex_dest == id_rs) || (id_uses_rt && (r_ex_dest == id_rt)));

`ifdef HAZARD_FWD_EN
    // Only a load in EX cannot be forwarded in time; the next cycle it comes from WB
    assign stall = id_valid && !flush && w_ex_hit && r_ex_mem_read;

    // Operand selects for the EX instruction; the younger MEM result wins over WB
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (r_ex_valid) begin
            if (r_mem_valid && r_mem_we && (r_mem_dest == r_ex_rs)) begin
                fwd_a = 2'b10;
            end else if (r_wb_valid && r_wb_we && (r_wb_dest == r_ex_rs)) begin
                fwd_a = 2'b01;
            end
            if (r_ex_uses_rt) begin
                if (r_mem_valid && r_mem_we && (r_mem_dest == r_ex_rt)) begin
                    fwd_b = 2'b10;
                end else if (r_wb_valid && r_wb_we && (r_wb_dest == r_ex_rt)) begin
                    fwd_b = 2'b01;
                end
            end
        end
    end
`else
    logic w_mem_hit;
    logic w_unused_nofwd;

    // Without forwarding, any pending EX or MEM write to a source holds ID
    // until the producer is in WB, where the write-through regfile covers it
    assign w_mem_hit = r_mem_valid && r_mem_we &&
                       ((r_mem_dest == id_rs) || (id_uses_rt && (r_mem_dest == id_rt)));
    assign stall     = id_valid && !flush && (w_ex_hit || w_mem_hit);
    assign fwd_a     = 2'b00;
    assign fwd_b     = 2'b00;

    assign w_unused_nofwd = ^{r_ex_rs, r_ex_rt, r_ex_uses_rt, r_ex_mem_read};
`endif

    // Load the EX record from ID when accepted; otherwise insert a cleared bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid    <= 1'b0;
            r_ex_dest     <= '0;
            r_ex_rs       <= '0;
            r_ex_rt       <= '0;
            r_ex_uses_rt  <= 1'b0;
            r_ex_we       <= 1'b0;
            r_ex_mem_read <= 1'b0;
        end else if (w_accept) begin
            r_ex_valid    <= 1'b1;
            r_ex_dest     <= w_id_dest;
            r_ex_rs       <= id_rs;
            r_ex_rt       <= id_rt;
            r_ex_uses_rt  <= id_uses_rt;
            r_ex_we       <= w_id_we;
            r_ex_mem_read <= id_mem_read;
        end else begin
            r_ex_valid    <= 1'b0;
            r_ex_dest     <= '0;
            r_ex_rs       <= '0;
            r_ex_rt       <= '0;
            r_ex_uses_rt  <= 1'b0;
            r_ex_we       <= 1'b0;
            r_ex_mem_read <= 1'b0;
        end
    end

    // Shift the destination records from EX to MEM to WB every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_valid <= 1'b0;
            r_mem_dest  <= '0;
            r_mem_we    <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_dest   <= '0;
            r_wb_we     <= 1'b0;
        end else begin
            r_mem_valid <= r_ex_valid;
            r_mem_dest  <= r_ex_dest;
            r_mem_we    <= r_ex_we;
            r_wb_valid  <= r_mem_valid;
            r_wb_dest   <= r_mem_dest;
            r_wb_we     <= r_mem_we;
        end
    end

    // Count stall cycles, holding at all-ones rather than wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign ex_dest   = r_ex_dest;
    assign wb_dest   = r_wb_dest;
    assign wb_we     = r_wb_valid && r_wb_we;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Hazard controller for the 5-stage pipeline. It owns the destination-register selection: rd or rt, chosen per instruction by reg_dst. It tracks that destination through the EX, MEM and WB stages. From this state it generates the load-use stall, the bubble insertion and the ALU operand forwarding selects. It sits beside the ID/EX pipeline register and drives the forwarding muxes and the PC/IF-ID write enables.

Parameters:
REG_W, 5, width of a register index
CNT_W, 16, width of the saturating stall counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
id_valid  in  1  instruction present in ID
id_rs  in  REG_W  ID source register A
id_rt  in  REG_W  ID source B / alternate destination
id_rd  in  REG_W  ID destination when id_reg_dst=1
id_reg_dst  in  1  1: destination = id_rd; 0: destination = id_rt
id_reg_write  in  1  ID instruction writes the register file
id_mem_read  in  1  ID instruction is a load
id_uses_rt  in  1  rt is a source operand
flush  in  1  kill the ID instruction (taken branch/jump)
stall  out  1  hold PC and IF/ID; insert bubble into EX
ex_dest  out  REG_W  destination of the EX-stage instruction
fwd_a  out  2  EX operand A select: 00 regfile, 10 MEM result, 01 WB result
fwd_b  out  2  EX operand B select, same encoding
wb_dest  out  REG_W  WB-stage destination
wb_we  out  1  WB-stage register write enable (valid and reg_write and dest!=0)
stall_cnt  out  CNT_W  number of stall cycles since reset, saturating

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. On rst all stage records are cleared immediately (valid=0, fields 0) and stall_cnt is set to 0.
  - Consequence: stall=0, fwd_a=fwd_b=00, ex_dest=0, wb_dest=0, wb_we=0 while rst is high.
  - Reset mid-operation discards all in-flight records; there is no drain.
- Stage records:
  - EX record: valid, dest, rs, rt, uses_rt, we, mem_read.
  - MEM and WB records: valid, dest, we.
- ID destination: id_dest = id_reg_dst ? id_rd : id_rt. A record with dest==0 is stored with we forced to 0.
- Each rising edge:
  - MEM <= EX.
  - WB <= MEM.
  - EX <= ID record when id_valid && !flush && !stall; otherwise EX <= bubble (valid=0).
- stall (combinational from EX record and ID inputs) = id_valid && !flush && EX.valid && EX.we && EX.mem_read && (EX.dest==id_rs || (id_uses_rt && EX.dest==id_rt)).
  - A load-use hazard therefore gives exactly 1 stall cycle.
- fwd_a (combinational) = 10 if MEM.valid && MEM.we && MEM.dest==EX.rs; else 01 if WB.valid && WB.we && WB.dest==EX.rs; else 00.
  - Outputs 00 when EX.valid=0.
- fwd_b: same as fwd_a using EX.rt, and only when EX.uses_rt=1; otherwise 00.
- MEM match has priority over WB match when both match.
- Register 0 never matches: its we is forced 0.
- The register file is write-through, so a WB-vs-ID match never stalls.
- stall_cnt increments on each edge where stall=1 and saturates at all-ones.
- flush and a hazard in the same cycle: flush wins, stall=0, EX gets a bubble, stall_cnt is unchanged.
- Latency: ex_dest is valid the cycle after ID acceptance; wb_dest follows 2 cycles later.

Optional Feature:
Macro HAZARD_FWD_EN.
- Defined: forwarding as described above.
- Undefined: fwd_a and fwd_b are tied to 00. stall additionally asserts for any ID source matching a valid, writing EX or MEM destination (not only loads), until the producer reaches WB.
  - An ALU producer directly ahead of its consumer gives 2 stall cycles.
  - A load producer gives 2 stall cycles.
  - The bubble and flush rules are unchanged.

Test Plan:
1. Assert rst asynchronously mid-stream with records valid -> stall=0, fwd_a=fwd_b=00, wb_we=0, stall_cnt=0 before the next edge; no stale records after release.
2. id_rd=7, id_rt=3, id_reg_dst=1, id_reg_write=1 -> ex_dest=7 after one edge. Repeat with id_reg_dst=0 -> ex_dest=3. wb_dest equals the same value 2 edges later with wb_we=1.
3. Load to $8 followed by a consumer with id_rs=8 -> stall=1 for exactly one cycle and a bubble enters EX. Then the consumer enters EX with fwd_a=01; stall_cnt=1.
4. Two back-to-back ALU writes to $5, then a consumer with rs=rt=5 and uses_rt=1 -> fwd_a=fwd_b=10 (MEM priority over WB).
5. Producer writing $0 (id_rd=0, reg_dst=1), consumer with rs=0 -> fwd_a=00, no stall, wb_we=0.
6. Load-use condition with flush=1 in the same cycle -> stall=0, EX.valid=0 next cycle, stall_cnt unchanged. Without HAZARD_FWD_EN, an ALU producer followed by its consumer -> 2 stall cycles.
